// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side packer: word/beat widths and packer states.
package fifo_rd_pkg;

    localparam int DW = 18;

    typedef logic [DW-1:0]   word_t;
    typedef logic [2*DW-1:0] beat_t;

    typedef enum logic {
        IDLE     = 1'b0,
        LOW_HELD = 1'b1
    } pk_state_e;

endpackage

// File: rtl/sync_buf.sv
// Single-clock show-ahead FIFO: dout always presents the oldest entry while count != 0.
module sync_buf #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rp];

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a standard-read FIFO, packs word pairs into {word1, word0} beats on a
// valid/ready stream and checks the incrementing test pattern on the way in.
module fifo_rd_packer #(
    parameter int DW        = fifo_rd_pkg::DW,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DW-1:0]     fifo_dout,
    input  logic              fifo_valid,
    output logic [2*DW-1:0]   m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              seq_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [31:0]       word_cnt
);

    import fifo_rd_pkg::pk_state_e, fifo_rd_pkg::IDLE, fifo_rd_pkg::LOW_HELD;

    localparam int AW = $clog2(BUF_DEPTH);

    logic            inflight;
    logic            acc;
    logic [AW:0]     buf_count;
    logic [AW+1:0]   occ;
    logic [DW-1:0]   buf_dout;
    logic            pop;
    logic            ld_lo;
    logic            ld_beat;
    logic [DW-1:0]   word0;
    logic            synced;
    logic [DW-1:0]   expected;
    pk_state_e       state_q, state_d;

    // Reserve a slot for the outstanding read so the buffer can never overflow.
    assign occ        = {1'b0, buf_count} + {{(AW+1){1'b0}}, inflight};
    assign fifo_rd_en = ~fifo_empty & ~rst & (occ < (AW+2)'(BUF_DEPTH));
    assign acc        = fifo_valid & inflight;

    sync_buf #(
        .DW    (DW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (rd_clk),
        .rst   (rst),
        .push  (acc),
        .din   (fifo_dout),
        .pop   (pop),
        .dout  (buf_dout),
        .count (buf_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        ld_lo   = 1'b0;
        ld_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_count != '0) begin
                    pop     = 1'b1;
                    ld_lo   = 1'b1;
                    state_d = LOW_HELD;
                end
            end
            LOW_HELD: begin
                if (buf_count != '0 && (!m_valid || m_ready)) begin
                    pop     = 1'b1;
                    ld_beat = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word0   <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_lo) word0 <= buf_dout;
            if (ld_beat) begin
                m_data  <= {buf_dout, word0};
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // A read issued in the same cycle its predecessor returns keeps inflight high.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst)             inflight <= 1'b0;
        else if (fifo_rd_en) inflight <= 1'b1;
        else if (fifo_valid) inflight <= 1'b0;
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            synced   <= 1'b0;
            expected <= '0;
            seq_err  <= 1'b0;
            err_cnt  <= '0;
            word_cnt <= '0;
        end else if (acc) begin
            word_cnt <= word_cnt + 32'd1;
            synced   <= 1'b1;
            expected <= fifo_dout + DW'(1);
            if (synced && fifo_dout != expected) begin
                seq_err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench: behavioural standard-read FIFO source, beat monitor, hand-computed expectations.
module tb_fifo_rd_packer;

    localparam int DW    = 18;
    localparam int CNT_W = 16;

    logic              rd_clk = 1'b0;
    logic              rst    = 1'b1;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DW-1:0]     fifo_dout;
    logic              fifo_valid;
    logic [2*DW-1:0]   m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              seq_err;
    logic [CNT_W-1:0]  err_cnt;
    logic [31:0]       word_cnt;

    int total = 0;
    int bad   = 0;

    fifo_rd_packer #(.DW(DW), .BUF_DEPTH(4), .CNT_W(CNT_W)) dut (
        .rd_clk     (rd_clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_valid (fifo_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .seq_err    (seq_err),
        .err_cnt    (err_cnt),
        .word_cnt   (word_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // Source FIFO model: data and valid one cycle after rd_en.
    logic [DW-1:0] mem [0:127];
    logic [6:0]    wr_ptr = '0;
    logic [6:0]    rd_ptr = '0;
    logic          fv_m   = 1'b0;
    logic [DW-1:0] fd_m   = '0;
    logic          inj_v  = 1'b0;
    logic [DW-1:0] inj_d  = '0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_valid = fv_m | inj_v;
    assign fifo_dout  = inj_v ? inj_d : fd_m;

    always @(posedge rd_clk) begin
        if (rst) begin
            fv_m   <= 1'b0;
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fv_m   <= 1'b1;
            fd_m   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 7'd1;
        end else begin
            fv_m   <= 1'b0;
        end
    end

    logic [2*DW-1:0] got_q [$];

    always @(negedge rd_clk) begin
        if (!rst && m_valid && m_ready) got_q.push_back(m_data);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 7'd1;
    endtask

    task automatic do_reset();
        tick(1);
        rst = 1'b1;
        tick(3);
        got_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (got_q.size() < n && c < 200) begin
            tick(1);
            c++;
        end
        chk("beat_count", 64'(got_q.size()), 64'(n));
    endtask

    function automatic logic [2*DW-1:0] beat(input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        return {hi, lo};
    endfunction

    initial begin
        tick(3);
        chk("rst_m_valid",  64'(m_valid),    64'd0);
        chk("rst_m_data",   64'(m_data),     64'd0);
        chk("rst_seq_err",  64'(seq_err),    64'd0);
        chk("rst_err_cnt",  64'(err_cnt),    64'd0);
        chk("rst_word_cnt", 64'(word_cnt),   64'd0);
        chk("rst_rd_en",    64'(fifo_rd_en), 64'd0);
        rst = 1'b0;

        // Straight stream of 0..9 with a free-running sink.
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) load(DW'(i));
        wait_beats(5);
        for (int k = 0; k < 5; k++)
            chk("t1_beat", 64'(got_q[k]), 64'(beat(DW'(2*k+1), DW'(2*k))));
        tick(2);
        chk("t1_seq_err",  64'(seq_err),  64'd0);
        chk("t1_word_cnt", 64'(word_cnt), 64'd10);
        chk("t1_m_valid",  64'(m_valid),  64'd0);

        // Backpressure: 2 words in the beat, 1 held low, 4 buffered -> 7 reads, then stall.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) load(DW'(i));
        tick(20);
        chk("t2_m_valid",  64'(m_valid),    64'd1);
        chk("t2_m_data",   64'(m_data),     64'(beat(18'd1, 18'd0)));
        chk("t2_rd_en",    64'(fifo_rd_en), 64'd0);
        chk("t2_word_cnt", 64'(word_cnt),   64'd7);
        m_ready = 1'b1;
        wait_beats(8);
        for (int k = 0; k < 8; k++)
            chk("t2_beat", 64'(got_q[k]), 64'(beat(DW'(2*k+1), DW'(2*k))));
        chk("t2_word_cnt_end", 64'(word_cnt), 64'd16);

        // Sequence gap 6 -> 8 flags one error; the checker resyncs afterwards.
        do_reset();
        m_ready = 1'b1;
        load(18'd5); load(18'd6); load(18'd8); load(18'd9);
        wait_beats(2);
        chk("t3_beat0",   64'(got_q[0]), 64'(beat(18'd6, 18'd5)));
        chk("t3_beat1",   64'(got_q[1]), 64'(beat(18'd9, 18'd8)));
        chk("t3_seq_err", 64'(seq_err),  64'd1);
        chk("t3_err_cnt", 64'(err_cnt),  64'd1);
        load(18'd10); load(18'd11);
        wait_beats(3);
        chk("t3_beat2",      64'(got_q[2]), 64'(beat(18'd11, 18'd10)));
        chk("t3_err_cnt_rs", 64'(err_cnt),  64'd1);
        chk("t3_seq_sticky", 64'(seq_err),  64'd1);

        // Pattern wrap at 2^DW is not an error.
        do_reset();
        load(18'h3FFFE); load(18'h3FFFF); load(18'h00000); load(18'h00001);
        wait_beats(2);
        chk("t4_beat0",   64'(got_q[0]), 64'(beat(18'h3FFFF, 18'h3FFFE)));
        chk("t4_beat1",   64'(got_q[1]), 64'(beat(18'h00001, 18'h00000)));
        chk("t4_seq_err", 64'(seq_err),  64'd0);
        chk("t4_err_cnt", 64'(err_cnt),  64'd0);

        // Odd word count: the third word stays held until its partner arrives.
        do_reset();
        load(18'd0); load(18'd1); load(18'd2);
        wait_beats(1);
        tick(5);
        chk("t5_beat0",    64'(got_q[0]), 64'(beat(18'd1, 18'd0)));
        chk("t5_m_valid",  64'(m_valid),  64'd0);
        chk("t5_word_cnt", 64'(word_cnt), 64'd3);
        load(18'd3);
        wait_beats(2);
        chk("t5_beat1",    64'(got_q[1]), 64'(beat(18'd3, 18'd2)));

        // Asynchronous reset while a beat is pending and a low word is held.
        do_reset();
        m_ready = 1'b0;
        load(18'd7); load(18'd9); load(18'd10);
        tick(12);
        chk("t6_pre_m_valid",  64'(m_valid),  64'd1);
        chk("t6_pre_seq_err",  64'(seq_err),  64'd1);
        chk("t6_pre_err_cnt",  64'(err_cnt),  64'd1);
        chk("t6_pre_word_cnt", 64'(word_cnt), 64'd3);
        @(negedge rd_clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_m_valid",  64'(m_valid),  64'd0);
        chk("t6_rst_seq_err",  64'(seq_err),  64'd0);
        chk("t6_rst_err_cnt",  64'(err_cnt),  64'd0);
        chk("t6_rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("t6_rst_m_data",   64'(m_data),   64'd0);
        tick(2);
        got_q.delete();
        rst   = 1'b0;
        inj_v = 1'b1;
        inj_d = 18'd55;
        tick(1);
        inj_v = 1'b0;
        tick(2);
        chk("t6_stray_valid", 64'(word_cnt), 64'd0);
        m_ready = 1'b1;
        load(18'd100); load(18'd101);
        wait_beats(1);
        chk("t6_beat0",    64'(got_q[0]), 64'(beat(18'd101, 18'd100)));
        chk("t6_seq_err",  64'(seq_err),  64'd0);
        chk("t6_err_cnt",  64'(err_cnt),  64'd0);
        chk("t6_word_cnt", 64'(word_cnt), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
